// File: rtl/pc_ras_unit.sv
// Program counter with prioritised trap/redirect/stall control, target alignment
// checking and a circular return-address stack that predicts ret targets.
module pc_ras_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4,
    parameter bit              COMPRESSED   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            inst_c,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            misaligned
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = COMPRESSED ? XLEN'(1) : XLEN'(3);

    logic [XLEN-1:0]                 pc_q, pc_d;
    logic                            mis_q, mis_d;
    logic [PW-1:0]                   ptr_q, ptr_d, ptr_inc;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [RAS_DEPTH-1:0][XLEN-1:0]  ras_q, ras_d;
    logic [XLEN-1:0]                 step, seq;
    logic                            has_entry;

    assign step      = (COMPRESSED && inst_c) ? XLEN'(2) : XLEN'(4);
    assign seq       = pc_q + step;
    assign has_entry = (cnt_q != '0);
    assign ptr_inc   = ptr_q + PW'(1);

    // Outputs depend on registered state only.
    assign pc         = pc_q;
    assign misaligned = mis_q;
    assign ras_empty  = !has_entry;
    assign ras_top    = has_entry ? ras_q[ptr_q] : '0;

    always_comb begin
        pc_d  = pc_q;
        mis_d = 1'b0;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ras_d = ras_q;
        if (trap) begin
            // Entries stay in place but are invalidated by the zero count.
            pc_d  = trap_vector & ~ALIGN_MASK;
            mis_d = |(trap_vector & ALIGN_MASK);
            cnt_d = '0;
        end else if (redirect) begin
            pc_d  = redirect_target & ~ALIGN_MASK;
            mis_d = |(redirect_target & ALIGN_MASK);
        end else if (!stall) begin
            if (ret && has_entry) begin
                pc_d = ras_q[ptr_q];
                if (call) begin
                    ras_d[ptr_q] = seq;
                end else begin
                    ptr_d = ptr_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end else begin
                pc_d = seq;
                if (call) begin
                    // When full the write lands on the oldest entry.
                    ras_d[ptr_inc] = seq;
                    ptr_d          = ptr_inc;
                    if (cnt_q != CW'(RAS_DEPTH))
                        cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
            ras_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: two configurations share stimulus and are checked
// every cycle against a stack-based behavioural model.
module tb_pc_ras_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, trap, inst_c, call, ret;
    logic [31:0] redirect_target, trap_vector;
    logic [31:0] pc0, top0, pc1, top1;
    logic        empty0, mis0, empty1, mis1;
    int          n_chk = 0, n_pass = 0;
    bit          chk_on = 1'b0;

    always #5 clk = ~clk;

    pc_ras_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .COMPRESSED(1'b0)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .trap(trap), .trap_vector(trap_vector),
        .inst_c(inst_c), .call(call), .ret(ret),
        .pc(pc0), .ras_top(top0), .ras_empty(empty0), .misaligned(mis0));

    pc_ras_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .COMPRESSED(1'b1)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .trap(trap), .trap_vector(trap_vector),
        .inst_c(inst_c), .call(call), .ret(ret),
        .pc(pc1), .ras_top(top1), .ras_empty(empty1), .misaligned(mis1));

    // Model: stk[0] is the newest return address; cnt valid entries from the top.
    typedef struct packed {
        logic [31:0]      pc;
        logic             mis;
        logic [2:0]       cnt;
        logic [3:0][31:0] stk;
    } ms_t;

    ms_t m0, m1;

    function automatic ms_t mreset(logic [31:0] rv);
        ms_t r = '0;
        r.pc = rv;
        return r;
    endfunction

    function automatic logic [31:0] mtop(ms_t s);
        return (s.cnt != 0) ? s.stk[0] : 32'h0;
    endfunction

    function automatic ms_t mnext(ms_t s, bit comp);
        ms_t         n    = s;
        logic [31:0] mask = comp ? 32'd1 : 32'd3;
        logic [31:0] seq  = s.pc + ((comp && inst_c) ? 32'd2 : 32'd4);
        n.mis = 1'b0;
        if (trap) begin
            n.pc  = trap_vector & ~mask;
            n.mis = (trap_vector & mask) != 0;
            n.cnt = 0;
        end else if (redirect) begin
            n.pc  = redirect_target & ~mask;
            n.mis = (redirect_target & mask) != 0;
        end else if (!stall) begin
            if (ret && s.cnt > 0) begin
                n.pc = s.stk[0];
                if (call) n.stk[0] = seq;
                else begin
                    for (int i = 0; i < 3; i++) n.stk[i] = s.stk[i+1];
                    n.cnt = s.cnt - 1;
                end
            end else begin
                n.pc = seq;
                if (call) begin
                    for (int i = 3; i > 0; i--) n.stk[i] = s.stk[i-1];
                    n.stk[0] = seq;
                    if (s.cnt < 4) n.cnt = s.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mreset(32'h100);
            m1 <= mreset(32'h0);
        end else begin
            m0 <= mnext(m0, 1'b0);
            m1 <= mnext(m1, 1'b1);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc0",    pc0,             m0.pc);
            chk("top0",   top0,            mtop(m0));
            chk("empty0", 32'(empty0),     32'(m0.cnt == 0));
            chk("mis0",   32'(mis0),       32'(m0.mis));
            chk("pc1",    pc1,             m1.pc);
            chk("top1",   top1,            mtop(m1));
            chk("empty1", 32'(empty1),     32'(m1.cnt == 0));
            chk("mis1",   32'(mis1),       32'(m1.mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect = 0; trap = 0; inst_c = 0; call = 0; ret = 0;
        redirect_target = 0; trap_vector = 0;
    endtask

    task automatic go_to(logic [31:0] a);
        idle(); redirect = 1; redirect_target = a; tick(); idle();
    endtask

    task automatic do_call();
        call = 1; tick(); call = 0;
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_on = 1;
        chk("rst_pc0", pc0, 32'h100);
        chk("rst_empty0", 32'(empty0), 32'd1);
        chk("rst_pc1", pc1, 32'h0);

        tick(); chk("seq_pc0_a", pc0, 32'h104); chk("model_pc0_a", m0.pc, 32'h104);
        tick(); chk("seq_pc0_b", pc0, 32'h108);
        tick(); chk("seq_pc0_c", pc0, 32'h10C);

        go_to(32'h0);
        inst_c = 1; tick(); chk("c_pc1_a", pc1, 32'h2);
        inst_c = 0; tick(); chk("c_pc1_b", pc1, 32'h6);
        inst_c = 1; tick(); chk("c_pc1_c", pc1, 32'h8); chk("model_pc1_c", m1.pc, 32'h8);
        chk("nc_pc0", pc0, 32'hC);

        go_to(32'hFFFF_FFFC);
        tick(); chk("wrap_pc0", pc0, 32'h0); chk("wrap_pc1", pc1, 32'h0);

        do_call(); chk("call_nonempty", 32'(empty0), 32'd0);
        trap = 1; trap_vector = 32'h800; redirect = 1; redirect_target = 32'h400; stall = 1;
        tick(); idle();
        chk("trap_pc0", pc0, 32'h800); chk("trap_empty0", 32'(empty0), 32'd1);

        go_to(32'h403);
        chk("mis_pc0", pc0, 32'h400); chk("mis_flag0", 32'(mis0), 32'd1);
        chk("mis_pc1", pc1, 32'h402); chk("mis_flag1", 32'(mis1), 32'd1);
        tick(); chk("mis_clear0", 32'(mis0), 32'd0); chk("mis_next_pc0", pc0, 32'h404);

        for (int a = 32'h10; a <= 32'h50; a += 32'h10) begin
            go_to(a);
            do_call();
        end
        chk("full_top0", top0, 32'h54); chk("model_full_top", mtop(m0), 32'h54);
        chk("full_cnt", 32'(m0.cnt), 32'd4);
        ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("ret_pc0", pc0, ret_exp[i]);
        end
        chk("ret_empty0", 32'(empty0), 32'd1);
        tick(); chk("ret_underflow_pc0", pc0, 32'h28);
        idle();

        go_to(32'h20); do_call();
        go_to(32'h80);
        call = 1; ret = 1; tick(); idle();
        chk("cr_pc0", pc0, 32'h24); chk("cr_top0", top0, 32'h84); chk("cr_empty0", 32'(empty0), 32'd0);
        ret = 1; tick(); idle();
        chk("cr_pop_pc0", pc0, 32'h84); chk("cr_pop_empty0", 32'(empty0), 32'd1);

        do_call(); do_call(); do_call();
        chk("pre_rst_cnt", 32'(m0.cnt), 32'd3);
        #2 rst = 1;
        #1;
        chk("async_pc0", pc0, 32'h100); chk("async_empty0", 32'(empty0), 32'd1);
        chk("async_pc1", pc1, 32'h0);
        rst = 0;
        tick(); chk("post_rst_pc0", pc0, 32'h104);

        stall = 1; call = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_pc0", pc0, 32'h104); chk("stall_empty0", 32'(empty0), 32'd1);
        end
        idle(); tick(); chk("unstall_pc0", pc0, 32'h108);

        for (int i = 0; i < 3000; i++) begin
            trap            = ($urandom_range(99) < 3);
            redirect        = ($urandom_range(99) < 10);
            stall           = ($urandom_range(99) < 15);
            call            = ($urandom_range(99) < 30);
            ret             = ($urandom_range(99) < 30);
            inst_c          = 1'($urandom_range(1));
            trap_vector     = $urandom;
            redirect_target = $urandom;
            if ($urandom_range(199) == 0) begin
                #1 rst = 1;
                #1 rst = 0;
            end
            tick();
        end
        idle();
        tick();
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
